// File: rtl/if_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// if_fetch_sequencer
//
// Next-PC controller for the IF stage. Issues one I-cache request at a time,
// buffers the returning fetch group in a hold register and presents it to the
// decode queue. The next PC is chosen in priority order: flush redirect,
// predicted-taken target, sequential (pc + FETCH_WIDTH*INSTR_BYTES, modulo
// 2^PC_BITS). Responses made stale by a flush are drained and discarded.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   flush_valid_i/flush_pc_i   redirect from execute, single-cycle pulse
//   icache_req_valid_o/_ready_i/_pc_o   I-cache request handshake + address
//   icache_resp_valid_i/_data_i         response for the outstanding request
//   pred_taken_i/pred_target_i predictor verdict for the returning group
//   fetch_valid_o/_ready_i     group handshake towards decode
//   fetch_pc_o/_data_o/_taken_o  presented group (registered)
//   state_o                    FSM state (REQ=0, WAIT=1, HOLD=2, DRAIN=3)
// ---------------------------------------------------------------------------
module if_fetch_sequencer #(
  parameter int                 PC_BITS     = 32,
  parameter int                 FETCH_WIDTH = 2,
  parameter int                 INSTR_BYTES = 4,
  parameter logic [PC_BITS-1:0] RESET_PC    = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_valid_i,
  input  logic [PC_BITS-1:0]       flush_pc_i,
  output logic                     icache_req_valid_o,
  input  logic                     icache_req_ready_i,
  output logic [PC_BITS-1:0]       icache_req_pc_o,
  input  logic                     icache_resp_valid_i,
  input  logic [FETCH_WIDTH*32-1:0] icache_resp_data_i,
  input  logic                     pred_taken_i,
  input  logic [PC_BITS-1:0]       pred_target_i,
  output logic                     fetch_valid_o,
  input  logic                     fetch_ready_i,
  output logic [PC_BITS-1:0]       fetch_pc_o,
  output logic [FETCH_WIDTH*32-1:0] fetch_data_o,
  output logic                     fetch_taken_o,
  output logic [1:0]               state_o
);

  localparam int                 DATA_BITS = FETCH_WIDTH * 32;
  localparam logic [PC_BITS-1:0] PC_STEP   = PC_BITS'(FETCH_WIDTH * INSTR_BYTES);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [PC_BITS-1:0]    r_pc;          // address of the next request to issue
  logic [PC_BITS-1:0]    w_pc_next;
  logic                  r_run;         // low for the first cycle after reset release
  logic [DATA_BITS-1:0]  r_hold_data;
  logic [PC_BITS-1:0]    r_hold_pc;
  logic                  r_hold_taken;
  logic                  w_capture;
  logic                  w_req_fire;

  // r_run keeps the request port quiet while in reset and for the release
  // cycle, so the first request appears the cycle after rst_n deasserts.
  assign icache_req_valid_o = r_run && (r_state == S_REQ);
  assign icache_req_pc_o    = r_pc;
  assign w_req_fire         = icache_req_valid_o && icache_req_ready_i;

  // Decode sees only registered values; nothing from icache_resp reaches
  // fetch_* combinationally.
  assign fetch_valid_o = (r_state == S_HOLD);
  assign fetch_pc_o    = r_hold_pc;
  assign fetch_data_o  = r_hold_data;
  assign fetch_taken_o = r_hold_taken;
  assign state_o       = r_state;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_capture    = 1'b0;

    case (r_state)
      S_REQ: begin
        // A request accepted in the same cycle as a flush is for the old
        // path; its response must still be swallowed in DRAIN.
        if (w_req_fire) w_state_next = flush_valid_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (icache_resp_valid_i) begin
          if (flush_valid_i) begin
            w_state_next = S_REQ;          // response is stale, drop it
          end else begin
            w_state_next = S_HOLD;
            w_capture    = 1'b1;
            w_pc_next    = pred_taken_i ? pred_target_i : r_pc + PC_STEP;
          end
        end else if (flush_valid_i) begin
          w_state_next = S_DRAIN;
        end
      end
      S_HOLD: begin
        // A flush drops the held group; a same-cycle fetch_ready still
        // delivered it, and both cases leave HOLD.
        if (flush_valid_i || fetch_ready_i) w_state_next = S_REQ;
      end
      S_DRAIN: begin
        // The only outstanding request is stale, so its response ends the
        // drain regardless of any further flush in this cycle.
        if (icache_resp_valid_i) w_state_next = S_REQ;
      end
      default: w_state_next = S_REQ;
    endcase

    // Flush overrides every other PC source; the last one wins.
    if (flush_valid_i) w_pc_next = flush_pc_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_run        <= 1'b0;
      // NOTE: the hold register is datapath, but it drives the fetch_*
      // outputs directly, so it is reset to give decode clean zeros.
      r_hold_data  <= '0;
      r_hold_pc    <= '0;
      r_hold_taken <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so all
      // registers update together from the values of the previous cycle.
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_run   <= 1'b1;
      if (w_capture) begin
        r_hold_data  <= icache_resp_data_i;
        r_hold_pc    <= r_pc;
        r_hold_taken <= pred_taken_i;
      end
    end
  end

  // A response is only legal while a request is outstanding.
  a_resp_only_when_outstanding : assert property (
    @(posedge clk) disable iff (!rst_n)
    icache_resp_valid_i |-> (r_state == S_WAIT || r_state == S_DRAIN)
  );

endmodule

// File: tb/tb_if_fetch_sequencer.sv
`timescale 1ns/1ps
module tb_if_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_valid_i;
  logic [31:0] flush_pc_i;
  logic        icache_req_valid_o;
  logic        icache_req_ready_i;
  logic [31:0] icache_req_pc_o;
  logic        icache_resp_valid_i;
  logic [63:0] icache_resp_data_i;
  logic        pred_taken_i;
  logic [31:0] pred_target_i;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [31:0] fetch_pc_o;
  logic [63:0] fetch_data_o;
  logic        fetch_taken_o;
  logic [1:0]  state_o;

  if_fetch_sequencer #(
    .PC_BITS(32), .FETCH_WIDTH(2), .INSTR_BYTES(4), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .flush_valid_i(flush_valid_i), .flush_pc_i(flush_pc_i),
    .icache_req_valid_o(icache_req_valid_o), .icache_req_ready_i(icache_req_ready_i),
    .icache_req_pc_o(icache_req_pc_o),
    .icache_resp_valid_i(icache_resp_valid_i), .icache_resp_data_i(icache_resp_data_i),
    .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
    .fetch_valid_o(fetch_valid_o), .fetch_ready_i(fetch_ready_i),
    .fetch_pc_o(fetch_pc_o), .fetch_data_o(fetch_data_o), .fetch_taken_o(fetch_taken_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] data;
    logic        taken;
  } grp_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int idle  = 0;

  // Stimulus controls (directed steps set these; random mode overwrites them).
  bit          rnd;
  bit          d_req_ready, d_fetch_ready, d_flush;
  logic [31:0] d_flush_pc;
  bit          p_en;
  logic [31:0] p_pc, p_target;
  logic [31:0] slow_pc;
  int          slow_lat;

  // I-cache model: one outstanding request, response after c_cnt idle cycles.
  bit          c_busy;
  logic [31:0] c_pc;
  int          c_cnt;

  // Reference model: next address to fetch, whether the outstanding request
  // is still on the correct path, and the group decode should see next.
  logic [31:0] m_pc;
  bit          m_live;
  grp_t        exp_q[$];

  logic [31:0] rq_log[$];
  logic [31:0] dl_pc[$];
  logic        dl_taken[$];
  int          dl_cyc[$];
  bit          last_hs_req;
  logic [31:0] last_req_pc;

  function automatic logic [63:0] gdata(input logic [31:0] pc);
    return {pc ^ 32'h5A5A_0F0F, ~pc + 32'd7};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, run the models against the current
  // (registered) outputs, then advance to 1ns after the next rising edge.
  task automatic cycle();
    bit          resp, hs_req, hs_fetch, tk;
    logic [31:0] tgt;
    if (rnd) begin
      d_req_ready   = ($urandom_range(3) != 0);
      d_fetch_ready = ($urandom_range(3) != 0);
      d_flush       = ($urandom_range(11) == 0);
      d_flush_pc    = $urandom;
    end
    resp = c_busy && (c_cnt == 0);
    if (resp && !rnd) begin
      tk  = p_en && (c_pc == p_pc);
      tgt = p_target;
    end else begin
      tk  = ($urandom_range(3) == 0);
      tgt = $urandom;
    end
    icache_req_ready_i  = d_req_ready;
    fetch_ready_i       = d_fetch_ready;
    flush_valid_i       = d_flush;
    flush_pc_i          = d_flush_pc;
    icache_resp_valid_i = resp;
    icache_resp_data_i  = resp ? gdata(c_pc) : {$urandom, $urandom};
    pred_taken_i        = tk;
    pred_target_i       = tgt;

    hs_req   = icache_req_valid_o && d_req_ready;
    hs_fetch = fetch_valid_o && d_fetch_ready;

    if (hs_fetch) begin
      chk("group_pending", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() != 0) begin
        chk("fetch_pc", fetch_pc_o, exp_q[0].pc);
        chk("fetch_data", fetch_data_o, exp_q[0].data);
        chk("fetch_taken", fetch_taken_o, exp_q[0].taken);
        void'(exp_q.pop_front());
      end
      dl_pc.push_back(fetch_pc_o);
      dl_taken.push_back(fetch_taken_o);
      dl_cyc.push_back(cyc);
    end
    if (hs_req) begin
      chk("one_outstanding", c_busy, 1'b0);
      chk("req_after_delivery", 32'(exp_q.size()), 32'd0);
      chk("req_pc", icache_req_pc_o, m_pc);
      rq_log.push_back(icache_req_pc_o);
      m_live = 1'b1;
    end
    if (resp) begin
      if (m_live && !d_flush) begin
        exp_q.push_back('{pc: c_pc, data: gdata(c_pc), taken: tk});
        m_pc = tk ? tgt : c_pc + 32'd8;
      end
      m_live = 1'b0;
    end
    if (d_flush) begin
      m_pc   = d_flush_pc;
      m_live = 1'b0;
      exp_q.delete();
    end

    if (resp) c_busy = 1'b0;
    else if (c_busy) c_cnt--;
    if (hs_req) begin
      c_busy = 1'b1;
      c_pc   = icache_req_pc_o;
      c_cnt  = rnd ? int'($urandom_range(3)) : ((icache_req_pc_o == slow_pc) ? slow_lat : 0);
    end
    last_hs_req = hs_req;
    last_req_pc = icache_req_pc_o;

    if (hs_req || hs_fetch) idle = 0;
    else idle++;
    if (idle > 60) begin
      chk("progress_watchdog", 32'(idle), 32'd0);
      idle = 0;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n               = 1'b0;
    flush_valid_i       = 1'b0;
    flush_pc_i          = '0;
    icache_req_ready_i  = 1'b0;
    icache_resp_valid_i = 1'b0;
    icache_resp_data_i  = '0;
    pred_taken_i        = 1'b0;
    pred_target_i       = '0;
    fetch_ready_i       = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req_valid", icache_req_valid_o, 1'b0);
    chk("rst_fetch_valid", fetch_valid_o, 1'b0);
    chk("rst_state", state_o, 2'd0);
    chk("rst_fetch_pc", fetch_pc_o, 32'd0);
    chk("rst_fetch_data", fetch_data_o, 64'd0);
    chk("rst_fetch_taken", fetch_taken_o, 1'b0);
    rst_n = 1'b1;
    chk("release_req_quiet", icache_req_valid_o, 1'b0);
    m_pc = 32'd0; m_live = 1'b0; exp_q.delete();
    c_busy = 1'b0; c_cnt = 0; c_pc = '0;
    rq_log.delete(); dl_pc.delete(); dl_taken.delete(); dl_cyc.delete();
    idle = 0; rnd = 1'b0; p_en = 1'b0; p_pc = '0; p_target = '0;
    slow_pc = 32'hFFFF_FFFF; slow_lat = 0;
    d_req_ready = 1'b1; d_fetch_ready = 1'b1; d_flush = 1'b0; d_flush_pc = '0;
  endtask

  task automatic run_until_req(input logic [31:0] pc, input int budget, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      cycle();
      if (last_hs_req && last_req_pc == pc) found = 1'b1;
    end
    chk(tag, found, 1'b1);
  endtask

  task automatic run_until_groups(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && dl_pc.size() < n; i++) cycle();
    chk(tag, 32'(dl_pc.size()), 32'(n));
  endtask

  initial begin
    int n16;

    // Sequential fetch: 0, 8, 16, 24, one group every 3 cycles.
    do_reset();
    cycle();
    chk("first_req_valid", icache_req_valid_o, 1'b1);
    chk("first_req_pc", icache_req_pc_o, 32'd0);
    run_until_groups(4, 40, "seq_groups");
    if (dl_pc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("seq_pc", dl_pc[i], 32'(8 * i));
        chk("seq_taken", dl_taken[i], 1'b0);
        if (i > 0) chk("seq_spacing", 32'(dl_cyc[i] - dl_cyc[i-1]), 32'd3);
      end
    end

    // Predicted-taken at pc 8 with target 40.
    do_reset();
    p_en = 1'b1; p_pc = 32'd8; p_target = 32'd40;
    run_until_groups(4, 40, "pred_groups");
    if (dl_pc.size() == 4) begin
      chk("pred_pc1", dl_pc[1], 32'd8);
      chk("pred_taken1", dl_taken[1], 1'b1);
      chk("pred_pc2", dl_pc[2], 32'd40);
      chk("pred_pc3", dl_pc[3], 32'd48);
      chk("pred_taken3", dl_taken[3], 1'b0);
    end

    // Flush to 100 while waiting on pc 16; response arrives two cycles later.
    do_reset();
    slow_pc = 32'd16; slow_lat = 2;
    run_until_req(32'd16, 40, "reach_req16");
    chk("wait16_state", state_o, 2'd1);
    d_flush = 1'b1; d_flush_pc = 32'd100;
    cycle();
    d_flush = 1'b0;
    chk("drain_state_a", state_o, 2'd3);
    chk("drain_no_req", icache_req_valid_o, 1'b0);
    cycle();
    chk("drain_state_b", state_o, 2'd3);
    chk("drain_no_fetch", fetch_valid_o, 1'b0);
    cycle();
    chk("post_drain_state", state_o, 2'd0);
    chk("post_drain_pc", icache_req_pc_o, 32'd100);
    run_until_groups(3, 20, "flush_groups");
    if (dl_pc.size() == 3) chk("flush_group_pc", dl_pc[2], 32'd100);
    n16 = 0;
    foreach (dl_pc[i]) if (dl_pc[i] == 32'd16) n16++;
    chk("stale16_absent", 32'(n16), 32'd0);

    // Decode stall for 5 cycles while holding pc 24.
    do_reset();
    run_until_req(32'd24, 60, "reach_req24");
    d_fetch_ready = 1'b0;
    for (int i = 0; i < 10 && !fetch_valid_o; i++) cycle();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", fetch_valid_o, 1'b1);
      chk("stall_pc", fetch_pc_o, 32'd24);
      chk("stall_data", fetch_data_o, gdata(32'd24));
      chk("stall_no_req", icache_req_valid_o, 1'b0);
      cycle();
    end
    d_fetch_ready = 1'b1;
    cycle();
    chk("stall_release_req", icache_req_valid_o, 1'b1);
    chk("stall_release_pc", icache_req_pc_o, 32'd32);

    // Back-to-back flushes to 200 then 300 while the request is unaccepted.
    do_reset();
    d_req_ready = 1'b0;
    cycle();
    d_flush = 1'b1; d_flush_pc = 32'd200;
    cycle();
    d_flush_pc = 32'd300;
    cycle();
    d_flush = 1'b0;
    chk("b2b_state", state_o, 2'd0);
    chk("b2b_pc", icache_req_pc_o, 32'd300);
    d_req_ready = 1'b1;
    cycle();
    chk("b2b_reqs", 32'(rq_log.size()), 32'd1);
    if (rq_log.size() == 1) chk("b2b_req_pc", rq_log[0], 32'd300);

    // Sequential wrap from 0xFFFFFFF8 to 0.
    do_reset();
    d_req_ready = 1'b0;
    cycle();
    d_flush = 1'b1; d_flush_pc = 32'hFFFF_FFF8;
    cycle();
    d_flush = 1'b0; d_req_ready = 1'b1;
    run_until_req(32'hFFFF_FFF8, 5, "wrap_req_top");
    run_until_req(32'h0000_0000, 10, "wrap_req_zero");

    // Asynchronous reset in the middle of WAIT.
    do_reset();
    run_until_req(32'd8, 20, "reach_req8");
    chk("mid_wait_state", state_o, 2'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_req_valid", icache_req_valid_o, 1'b0);
    chk("async_fetch_valid", fetch_valid_o, 1'b0);
    chk("async_state", state_o, 2'd0);
    chk("async_fetch_data", fetch_data_o, 64'd0);
    do_reset();
    cycle();
    chk("post_rst_req_valid", icache_req_valid_o, 1'b1);
    chk("post_rst_req_pc", icache_req_pc_o, 32'd0);

    // Randomized traffic against the reference model.
    do_reset();
    rnd = 1'b1;
    for (int i = 0; i < 4000; i++) cycle();
    rnd = 1'b0;
    chk("rand_progress", (dl_pc.size() >= 100), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_sequencer.md
Name: if_fetch_sequencer

Overview:
- Next-PC controller for the superscalar IF stage. Sits between the branch-redirect sources and the I-cache request port, and feeds fetch groups to the decode queue.
- Keeps at most one I-cache request outstanding.
- Selects the next PC in priority order: flush redirect, then predicted-taken target, then sequential.
- Squashes responses that become stale after a flush.

Parameters:
- PC_BITS, 32, width of all PCs
- FETCH_WIDTH, 2, instructions per fetch group
- INSTR_BYTES, 4, bytes per instruction; sequential step = FETCH_WIDTH*INSTR_BYTES
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush_valid_i  in  1  redirect from execute (mispredict/exception); single-cycle pulse
- flush_pc_i  in  PC_BITS  redirect target
- icache_req_valid_o  out  1  request valid
- icache_req_ready_i  in  1  I-cache accepts request
- icache_req_pc_o  out  PC_BITS  request address
- icache_resp_valid_i  in  1  response for the outstanding request
- icache_resp_data_i  in  FETCH_WIDTH*32  instruction group
- pred_taken_i  in  1  predictor verdict for the group returning this cycle
- pred_target_i  in  PC_BITS  predicted target
- fetch_valid_o  out  1  group valid to decode
- fetch_ready_i  in  1  decode queue accepts
- fetch_pc_o  out  PC_BITS  PC of presented group
- fetch_data_o  out  FETCH_WIDTH*32  presented group
- fetch_taken_o  out  1  group ended in a predicted-taken branch
- state_o  out  2  FSM state, debug

Behaviour:
- Reset (async assert, sync release):
  - state=REQ(0), pc=RESET_PC
  - all valid outputs 0; held data/pc/taken cleared to 0
  - first request issued the cycle after rst_n deasserts
- FSM states: REQ=0, WAIT=1, HOLD=2, DRAIN=3.
- REQ:
  - icache_req_valid_o=1, icache_req_pc_o=pc
  - req_valid&req_ready moves to WAIT
  - valid stays asserted and pc stays stable until accepted
- WAIT:
  - On resp_valid, capture data/pc/pred_taken into the hold register and go to HOLD.
  - pc_next = pred_taken_i ? pred_target_i : pc + FETCH_WIDTH*INSTR_BYTES.
  - The add is modulo 2^PC_BITS; wrap is silent.
- HOLD:
  - fetch_valid_o=1; outputs come from registers (no combinational path from icache_resp to fetch_*).
  - On fetch_ready_i, go to REQ and issue the request for pc_next the next cycle.
  - Latency: request accept to fetch_valid_o is 1 cycle after resp_valid.
- Flush (flush_valid_i=1) has highest priority in every state:
  - pc <= flush_pc_i.
  - REQ: if the same-cycle request handshake occurs, it is treated as stale and the FSM goes to DRAIN; otherwise stay in REQ with the new pc. The old pc is never re-issued.
  - WAIT without resp_valid: go to DRAIN.
  - WAIT with resp_valid in the same cycle: discard the response and go to REQ.
  - HOLD: drop the held group, fetch_valid_o=0 the next cycle, go to REQ. A same-cycle fetch_ready handshake still counts as delivered.
  - DRAIN: stay in DRAIN with the updated pc.
- DRAIN:
  - No request issued; fetch_valid_o=0.
  - On resp_valid, discard the data and go to REQ with the latest flush pc.
- pred_taken_i/pred_target_i are sampled only in WAIT on resp_valid and ignored otherwise.
- icache_resp_valid_i outside WAIT/DRAIN is a protocol error. It is ignored, and an assertion covers it.
- Back-to-back flushes: the last one wins.
- Throughput ceiling: one group per 3 cycles (REQ, WAIT, HOLD) with a zero-wait cache and ready decode.
- Reset asserted mid-operation: immediate return to reset values. Any in-flight response after reset is not tracked; the I-cache is reset by the same rst_n.

Test Plan:
- Sequential fetch, FETCH_WIDTH=2, cache and decode always ready → groups at PCs 0, 8, 16, 24, each fetch_taken_o=0, one group every 3 cycles.
- Response for pc=8 with pred_taken_i=1, pred_target_i=40 → fetch_taken_o=1 for pc=8; next request pc=40, then 48.
- Flush to pc=100 while in WAIT for pc=16, response arrives 2 cycles later → state goes to DRAIN; pc=16 data never appears on fetch_*; next request pc=100.
- Decode stalls (fetch_ready_i=0 for 5 cycles) in HOLD at pc=24 → fetch_valid_o, pc and data stable for 5 cycles; no new I-cache request; request for pc=32 issued after release.
- Flush pulses at pc=200 then pc=300 on consecutive cycles in REQ → only pc=300 is ever presented on icache_req_pc_o.
- PC wrap with PC_BITS=32: pc=0xFFFFFFF8 → next sequential request pc=0x00000000.
- rst_n pulsed low mid-WAIT → outputs go to 0 asynchronously; first request after release is pc=RESET_PC.
